// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency mul/div with cancel and MTHI/MTLO.
// Optional MADD/MSUB accumulate is enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  state_e state, state_nx;
  op_e    opc;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] res_q;
  logic [2*WIDTH-1:0] res_start;
  logic [2*WIDTH-1:0] res_final;
  logic [CNT_W-1:0]   lat_start;

  logic idle_cmd, accept, finish, mthi_we, mtlo_we, is_acc;

  assign opc = op_e'(op);

  // Command decode
  always_comb begin
    is_acc = 1'b0;
`ifdef MULDIV_MADD_EN
    is_acc = (opc == OP_MADD) || (opc == OP_MSUB);
`endif
    idle_cmd = start && !cancel && (state == IDLE);
    accept   = idle_cmd && ((opc == OP_MULT) || (opc == OP_MULTU) ||
                            (opc == OP_DIV)  || (opc == OP_DIVU)  || is_acc);
    mthi_we  = idle_cmd && (opc == OP_MTHI);
    mtlo_we  = idle_cmd && (opc == OP_MTLO);
    finish   = (state == RUN) && !cancel && (cnt == CNT_W'(1));
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cancel || (cnt == CNT_W'(1))) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign busy = (state == RUN);

  // Arithmetic datapath, evaluated on the issue cycle
  logic signed [2*WIDTH-1:0] sa_x, sb_x;
  logic        [2*WIDTH-1:0] sprod, uprod;
  logic signed [WIDTH-1:0]   sa, sb, sq, sr;
  logic        [WIDTH-1:0]   uq, ur;
  logic                      div_zero, div_ovf;

  assign sa_x  = {{WIDTH{a[WIDTH-1]}}, a};
  assign sb_x  = {{WIDTH{b[WIDTH-1]}}, b};
  assign sprod = sa_x * sb_x;
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign sa = a;
  assign sb = b;
  assign sq = sa / sb;
  assign sr = sa % sb;
  assign uq = a / b;
  assign ur = a % b;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // Zero divisor and signed overflow are forced explicitly; the raw operators are undefined there
  always_comb begin
    res_start = '0;
    lat_start = CNT_W'(MUL_LAT);
    case (opc)
      OP_MULT:  res_start = sprod;
      OP_MULTU: res_start = uprod;
      OP_DIV: begin
        lat_start = CNT_W'(DIV_LAT);
        if (div_zero)     res_start = {a, {WIDTH{1'b1}}};
        else if (div_ovf) res_start = {{WIDTH{1'b0}}, a};
        else              res_start = {sr, sq};
      end
      OP_DIVU: begin
        lat_start = CNT_W'(DIV_LAT);
        if (div_zero) res_start = {a, {WIDTH{1'b1}}};
        else          res_start = {ur, uq};
      end
      OP_MADD, OP_MSUB: res_start = sprod;
      default: res_start = '0;
    endcase
  end

`ifdef MULDIV_MADD_EN
  logic acc_q, sub_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b0;
      sub_q <= 1'b0;
    end else if (accept) begin
      acc_q <= is_acc;
      sub_q <= (opc == OP_MSUB);
    end
  end

  // Accumulate against HI/LO as they stand at completion
  always_comb begin
    res_final = res_q;
    if (acc_q) res_final = sub_q ? ({hi, lo} - res_q) : ({hi, lo} + res_q);
  end
`else
  assign res_final = res_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      res_q <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        cnt   <= lat_start;
        res_q <= res_start;
      end else if (state == RUN) begin
        cnt <= cancel ? '0 : cnt - CNT_W'(1);
      end
      if (finish) begin
        {hi, lo} <= res_final;
      end else begin
        if (mthi_we) hi <= a;
        if (mtlo_we) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, cancel/reset sequences, random ops vs model.
module tb_muldiv_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5, MADD = 3'd6, MSUB = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference model straight from the architectural definition of each op
  function automatic void model(input logic [2:0] o, input logic [31:0] x, y,
                                inout logic [31:0] h, l, output int lat);
    longint sx, sy, mx, my, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lat = 0;
    case (o)
      MULT:  begin p = sx * sy; {h, l} = p; lat = MUL_LAT; end
      MULTU: begin p = {32'd0, x} * {32'd0, y}; {h, l} = p; lat = MUL_LAT; end
      DIV, DIVU: begin
        lat = DIV_LAT;
        if (y == 0) begin l = '1; h = x; end
        else if (o == DIV) begin
          mx = (sx < 0) ? -sx : sx;
          my = (sy < 0) ? -sy : sy;
          q = mx / my;
          r = mx % my;
          if ((sx < 0) != (sy < 0)) q = -q;
          if (sx < 0) r = -r;
          l = q[31:0];
          h = r[31:0];
        end else begin
          l = x / y;
          h = x % y;
        end
      end
      MTHI: h = x;
      MTLO: l = x;
`ifdef MULDIV_MADD_EN
      MADD: begin p = {h, l} + (sx * sy); {h, l} = p; lat = MUL_LAT; end
      MSUB: begin p = {h, l} - (sx * sy); {h, l} = p; lat = MUL_LAT; end
`endif
      default: ;
    endcase
  endfunction

  task automatic check_op(input string nm, input logic [2:0] o, input logic [31:0] x, y,
                          input logic [31:0] eh, el, input int lat);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (lat == 0) begin
      chk({nm, ".busy"}, 64'(busy), 64'd0);
      chk({nm, ".done"}, 64'(done), 64'd0);
    end else begin
      n = 0;
      while (busy && n < 64) begin
        n++;
        @(negedge clk);
      end
      chk({nm, ".lat"}, 64'(n), 64'(lat));
      chk({nm, ".done"}, 64'(done), 64'd1);
    end
    chk({nm, ".hi"}, 64'(hi), 64'(eh));
    chk({nm, ".lo"}, 64'(lo), 64'(el));
    if (lat != 0) begin
      @(negedge clk);
      chk({nm, ".done_clr"}, 64'(done), 64'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, eh, el;
    int          lat;

    tbl.push_back('{MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    tbl.push_back('{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5});
    tbl.push_back('{DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    tbl.push_back('{DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 10});
    tbl.push_back('{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10});
`ifdef MULDIV_MADD_EN
    tbl.push_back('{MTLO,  32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 0});
    tbl.push_back('{MADD,  32'd1,         32'd1, 32'd1, 32'd0,         5});
    tbl.push_back('{MSUB,  32'd1,         32'd1, 32'd0, 32'hFFFF_FFFF, 5});
`else
    tbl.push_back('{MADD,  32'd5, 32'd5, 32'd0, 32'h8000_0000, 0});
    tbl.push_back('{MSUB,  32'd5, 32'd5, 32'd0, 32'h8000_0000, 0});
`endif
    tbl.push_back('{MTLO,  32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0, 0});
    tbl.push_back('{MTHI,  32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 0});

    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                              tbl[i].eh, tbl[i].el, tbl[i].lat);
    m_hi = 32'h1234_5678;
    m_lo = 32'd0;

    // MULT cancelled during its third busy cycle
    @(negedge clk);
    op = MULT; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cxl.busy1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl.busy", 64'(busy), 64'd0);
    chk("cxl.hi", 64'(hi), 64'h1234_5678);
    chk("cxl.lo", 64'(lo), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("cxl.nodone", 64'(done), 64'd0);
      @(negedge clk);
    end

    // start together with cancel in IDLE is dropped
    op = MTLO; a = 32'hAAAA_5555; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    chk("cxs.mtlo", 64'(lo), 64'd0);
    op = MULT; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cxs.busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("cxs.busy2", 64'(busy), 64'd0);
    chk("cxs.hi", 64'(hi), 64'h1234_5678);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      eh = m_hi;
      el = m_lo;
      model(ro, ra, rb, eh, el, lat);
      check_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, eh, el, lat);
      m_hi = eh;
      m_lo = el;
    end

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    op = DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.hi", 64'(hi), 64'd0);
    chk("arst.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DIV_LAT) @(negedge clk);
    chk("arst.quiet", 64'({busy, done, hi, lo}), 64'd0);

    check_op("post", MULT, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
